dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the MEM stage's data port (mem_ce/mem_we/mem_sel/mem_addr/mem_data).
- Holds a word-organised RAM and serves byte-lane-masked reads and writes.
- Inserts a programmable number of wait states and raises a stall request so the pipeline holds the MEM-stage request stable until the access completes.

Parameters:
- ADDR_W, 12: word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2: wait states per access (≥1); only used when DMEM_WAIT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_ce_i  in  1  request valid (chip enable).
- mem_we_i  in  1  1 = write, 0 = read.
- mem_sel_i  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
- mem_addr_i  in  32  byte address; word index = mem_addr_i[ADDR_W+1:2]; upper bits ignored (aliasing).
- mem_data_i  in  32  write data, full word, lane-aligned.
- mem_data_o  out  32  read data, full word, unmasked.
- stallreq_o  out  1  hold the pipeline; request inputs must stay stable while high.
- ack_o  out  1  one-cycle pulse marking access completion.

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset (rst=0, any time, including mid-access):
  - state→IDLE, wait counter→0.
  - mem_data_o=0, ack_o=0.
  - stallreq_o=0 while rst is low.
  - RAM contents are not cleared; a write still in WAIT is abandoned with no array update.
- IDLE:
  - stallreq_o = mem_ce_i (combinational), so the first cycle of a request already stalls.
  - On an edge with mem_ce_i=1: request accepted.
    - LATENCY=1 → DONE.
    - Otherwise → WAIT with counter=LATENCY-1.
  - mem_ce_i=0: stay in IDLE.
- WAIT:
  - stallreq_o=1; counter decrements every edge.
  - On the edge where the counter is 1 → DONE.
  - Total stalled cycles per access = LATENCY.
- Commit edge (entering DONE):
  - Write: each lane with mem_sel_i[n]=1 is written from mem_data_i; other lanes are unchanged.
  - sel=4'b0000 write: no array change, still completes normally (the MEM stage drives sel=0 on misaligned accesses).
  - Read: mem_data_o ← RAM[word index], all 4 bytes regardless of sel (the MEM stage performs lane extraction).
- DONE:
  - stallreq_o=0, ack_o=1; the pipeline advances on this edge.
  - Next state is always IDLE; a request present during DONE is not accepted (it is the completing one).
  - Back-to-back accesses therefore cost LATENCY+1 cycles each.
- mem_data_o holds its value until the next read commit; writes do not change it.
- Inputs that change during WAIT are a protocol violation; the values sampled at the commit edge are used.
- Read-after-write to the same word in consecutive accesses returns the newly written data.

Optional Feature:
- Macro: DMEM_WAIT_EN.
- Defined: the wait-state FSM described above, with LATENCY wait states.
- Undefined: zero-wait mode; FSM and counter are removed.
  - stallreq_o tied 0.
  - Writes commit on every edge with mem_ce_i=1 and mem_we_i=1.
  - mem_data_o = RAM[word index] combinationally when mem_ce_i=1 and mem_we_i=0, else 0.
  - ack_o = mem_ce_i.

Test Plan (DMEM_WAIT_EN defined, LATENCY=2 unless noted):
1. Reset then idle: rst=0→1 with ce=0 → mem_data_o=0, stallreq_o=0, ack_o=0 for 10 cycles.
2. Write then read: SW addr 0x10, data 0xDEADBEEF, sel 4'b1111 → stallreq_o high for exactly 2 cycles, ack_o one pulse. LW addr 0x10 → mem_data_o=0xDEADBEEF in the DONE cycle.
3. Byte lane: after test 2, write addr 0x11, sel 4'b0010, data 0x0000AA00 → read of 0x10 returns 0xDEADAAEF.
4. sel=0: write addr 0x10, sel 4'b0000, data 0x12345678 → ack_o pulses and a subsequent read still returns 0xDEADAAEF.
5. Reset mid-access: start a write of 0x55555555 to 0x20, assert rst during WAIT → stallreq_o=0 and state is IDLE. Read of 0x20 returns its pre-write value.
6. Back-to-back and aliasing: with ADDR_W=12, write 0x11111111 to 0x4000 then read 0x0000 with ce held high → read returns 0x11111111. Each access takes 3 cycles (2 stall + DONE). Separately, with LATENCY=1, each access stalls exactly 1 cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane-masked word RAM behind the MEM-stage data port.
// Define DMEM_WAIT_EN for LATENCY wait states with stall request; otherwise zero-wait.
module dmem_responder #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq_o,
   output logic        ack_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       rd_word;
   logic              wr_en;

   // Upper address bits alias onto the same words.
   assign word_idx = mem_addr_i[ADDR_W+1:2];

   // One byte-wide array per lane so masked writes need no read-modify-write.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_ram [DEPTH];

         always_ff @(posedge clk) begin
            if (wr_en && mem_sel_i[gi]) begin
               lane_ram[word_idx] <= mem_data_i[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = lane_ram[word_idx];
      end
   endgenerate

`ifdef DMEM_WAIT_EN
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              commit;

   // Commit happens on the edge that enters DONE.
   assign commit = rst && (((state == IDLE) && mem_ce_i && (LATENCY == 1)) ||
                           ((state == WAIT) && (wait_cnt == CNT_W'(1))));
   assign wr_en  = commit && mem_we_i;

   // The first request cycle already stalls, before the FSM has seen it.
   assign stallreq_o = rst && (((state == IDLE) && mem_ce_i) || (state == WAIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         mem_data_o <= '0;
         ack_o      <= 1'b0;
      end else begin
         ack_o <= commit;
         if (commit && !mem_we_i) begin
            mem_data_o <= rd_word;
         end
         case (state)
            IDLE: begin
               if (mem_ce_i) begin
                  if (LATENCY == 1) begin
                     state <= DONE;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   wire unused_ok = &{1'b0, mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};
`else
   assign wr_en      = mem_ce_i && mem_we_i;
   assign stallreq_o = 1'b0;
   assign ack_o      = mem_ce_i;
   assign mem_data_o = (mem_ce_i && !mem_we_i) ? rd_word : '0;

   wire unused_ok = &{1'b0, rst, (LATENCY > 0), mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; expectations follow DMEM_WAIT_EN.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce, ce1, we;
   logic [3:0]  sel;
   logic [31:0] addr, data;
   logic [31:0] data_o, data1_o;
   logic        stall, stall1, ack, ack1;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DMEM_WAIT_EN
   localparam int STALL2 = 2;
   localparam int STALL1 = 1;
   localparam logic [31:0] HOLD_EXP = 32'hDEADAAEF;
`else
   localparam int STALL2 = 0;
   localparam int STALL1 = 0;
   localparam logic [31:0] HOLD_EXP = 32'h0;
`endif

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(12), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_sel_i(sel),
      .mem_addr_i(addr), .mem_data_i(data), .mem_data_o(data_o),
      .stallreq_o(stall), .ack_o(ack)
   );

   dmem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .mem_ce_i(ce1), .mem_we_i(we), .mem_sel_i(sel),
      .mem_addr_i(addr), .mem_data_i(data), .mem_data_o(data1_o),
      .stallreq_o(stall1), .ack_o(ack1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one request and watch the selected instance until ack; ce is left asserted.
   task automatic do_access(input int which, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d,
                            output int stalls, output int cycles, output logic [31:0] rdata);
      logic acked;
      if (which == 0) ce = 1'b1; else ce1 = 1'b1;
      we = w; sel = s; addr = a; data = d;
      stalls = 0; cycles = 0; rdata = '0; acked = 1'b0;
      for (int i = 0; i < 16 && !acked; i++) begin
         @(negedge clk);
         cycles++;
         if ((which == 0) ? stall : stall1) stalls++;
         if ((which == 0) ? ack : ack1) begin
            acked = 1'b1;
            rdata = (which == 0) ? data_o : data1_o;
         end
      end
      check_eq("ack_seen", {63'd0, acked}, 64'd1);
      $display("access dut%0d we=%0b sel=%b addr=%h wdata=%h stalls=%0d cycles=%0d rdata=%h",
               which, w, s, a, d, stalls, cycles, rdata);
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      ce = 1'b0; ce1 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, cy;
      logic [31:0] rd;
      ce = 0; ce1 = 0; we = 0; sel = 0; addr = 0; data = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_ctrl", {60'd0, stall, ack, stall1, ack1}, 64'd0);
         check_eq("idle_data", {data_o, data1_o}, 64'd0);
      end
      @(posedge clk);
      #1;

      // Full-word write then read
      do_access(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, st, cy, rd);
      check_eq("sw_stalls", st, STALL2);
      check_eq("sw_cycles", cy, STALL2 + 1);
      go_idle();
      do_access(0, 1'b0, 4'b1111, 32'h10, 32'h0, st, cy, rd);
      check_eq("lw_data", rd, 32'hDEADBEEF);
      check_eq("lw_stalls", st, STALL2);
      go_idle();

      // Single lane write, read back with a narrow sel (data is unmasked)
      do_access(0, 1'b1, 4'b0010, 32'h11, 32'h0000AA00, st, cy, rd);
      go_idle();
      do_access(0, 1'b0, 4'b0001, 32'h10, 32'h0, st, cy, rd);
      check_eq("lane_data", rd, 32'hDEADAAEF);
      go_idle();

      // sel=0 write completes without touching the array; read data holds
      do_access(0, 1'b1, 4'b0000, 32'h10, 32'h12345678, st, cy, rd);
      check_eq("sel0_cycles", cy, STALL2 + 1);
      check_eq("sel0_hold", rd, HOLD_EXP);
      go_idle();
      do_access(0, 1'b0, 4'b1111, 32'h10, 32'h0, st, cy, rd);
      check_eq("sel0_data", rd, 32'hDEADAAEF);
      go_idle();

      // Reset mid-access abandons the write
      do_access(0, 1'b1, 4'b1111, 32'h20, 32'hA5A5A5A5, st, cy, rd);
      go_idle();
`ifdef DMEM_WAIT_EN
      ce = 1'b1; we = 1'b1; sel = 4'b1111; addr = 32'h20; data = 32'h55555555;
      @(posedge clk);
      #1;
      check_eq("wait_stall", {63'd0, stall}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("rst_ctrl", {62'd0, stall, ack}, 64'd0);
      check_eq("rst_data", data_o, 32'h0);
      @(posedge clk);
      #1;
      ce = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ctrl", {62'd0, stall, ack}, 64'd0);
      @(posedge clk);
      #1;
`endif
      do_access(0, 1'b0, 4'b1111, 32'h20, 32'h0, st, cy, rd);
      check_eq("rst_keep_data", rd, 32'hA5A5A5A5);
      check_eq("rst_keep_stalls", st, STALL2);
      go_idle();

      // Back-to-back with ce held, aliased address
      do_access(0, 1'b1, 4'b1111, 32'h4000, 32'h11111111, st, cy, rd);
      check_eq("b2b_w_cycles", cy, STALL2 + 1);
      do_access(0, 1'b0, 4'b1111, 32'h0000, 32'h0, st, cy, rd);
      check_eq("alias_data", rd, 32'h11111111);
      check_eq("b2b_r_cycles", cy, STALL2 + 1);
      go_idle();
      @(negedge clk);
      check_eq("ack_pulse_end", {62'd0, stall, ack}, 64'd0);
      @(posedge clk);
      #1;

      // Single wait-state instance
      do_access(1, 1'b1, 4'b1111, 32'h30, 32'hCAFEF00D, st, cy, rd);
      check_eq("lat1_w_stalls", st, STALL1);
      check_eq("lat1_w_cycles", cy, STALL1 + 1);
      go_idle();
      do_access(1, 1'b0, 4'b1111, 32'h30, 32'h0, st, cy, rd);
      check_eq("lat1_r_data", rd, 32'hCAFEF00D);
      check_eq("lat1_r_stalls", st, STALL1);
      go_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
